// File: rtl/fungen_pkg.sv
// fungen_pkg: shared constants and types for the function-generator front end.
//   FRAME_BITS  - bits per SPI command frame
//   CMD_W       - command byte width (first byte on the wire)
//   PAYLOAD_W   - payload width (remaining three bytes)
//   spi_state_t - SPI frame receiver states
package fungen_pkg;

    localparam int FRAME_BITS = 32;
    localparam int CMD_W      = 8;
    localparam int PAYLOAD_W  = 24;

    // IDLE : chip select high
    // SHIFT: chip select low, fewer than FRAME_BITS bits received
    // FULL : a complete frame has been received, further SCK edges ignored
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } spi_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for one asynchronous input followed by an
// edge-detect register. Rising and falling edges are reported as registered
// single-cycle pulses, SYNC_STAGES+1 cycles after the pin changes.
//
// Ports:
//   clk_i  - sampling clock
//   rst_i  - synchronous active-high reset (chain and pulses cleared to 0)
//   d_i    - asynchronous input
//   rise_o - one-cycle pulse on a 0->1 transition
//   fall_o - one-cycle pulse on a 1->0 transition
//
// SYNC_STAGES must be at least 2.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    // The chain resets to 0 so that an input already low at reset release
    // never produces a fall pulse: a frame in flight at reset is not resumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: SPI mode-0 slave front end. Oversamples SCK/MOSI/CS in the
// sys_clk_i domain, assembles one FRAME_BITS command frame per chip-select
// window and strobes it out as command byte + payload. Optionally shifts a
// status word back on MISO during the same window.
//
// Ports:
//   sys_clk_i     - system clock (only clock)
//   sys_rst_i     - synchronous active-high reset
//   int_clk_i     - SPI SCK (asynchronous)
//   int_mosi_i    - SPI data in, MSB first
//   int_cs_i      - SPI chip select, active low
//   int_miso_o    - SPI data out, MSB first
//   status_i      - readback word, latched at frame start
//   frame_cmd_o   - first byte of the last complete frame
//   frame_data_o  - remaining bytes of the last complete frame
//   frame_valid_o - one-cycle strobe when a complete frame is received
//   frame_err_o   - one-cycle strobe when a partial frame is aborted
//
// Strobe semantics: frame_valid_o / frame_err_o are single-cycle pulses with
// no back-pressure; frame_cmd_o/frame_data_o are valid in the pulse cycle and
// hold until the next complete frame.
//
// Build option: define SPI_MISO_READBACK_EN to build the MISO transmit path;
// without it int_miso_o is tied to 0 and status_i is ignored.
module spi_frame_slave
    import fungen_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = fungen_pkg::FRAME_BITS
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  int_clk_i,
    input  logic                  int_mosi_i,
    input  logic                  int_cs_i,
    output logic                  int_miso_o,
    input  logic [FRAME_BITS-1:0] status_i,
    output logic [CMD_W-1:0]      frame_cmd_o,
    output logic [PAYLOAD_W-1:0]  frame_data_o,
    output logic                  frame_valid_o,
    output logic                  frame_err_o
);

    localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i  (sys_clk_i),
        .rst_i  (sys_rst_i),
        .d_i    (int_clk_i),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (sys_clk_i),
        .rst_i  (sys_rst_i),
        .d_i    (int_cs_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // MOSI gets one extra flop beyond the sync chain so it lines up with the
    // registered SCK-rise pulse: the bit shifted in is the one at the pin edge.
    logic [SYNC_STAGES:0] mosi_q;
    logic                 mosi_s;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], int_mosi_i};
        end
    end

    assign mosi_s = mosi_q[SYNC_STAGES];

    spi_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [FRAME_BITS-1:0]  rx_q;
    logic [FRAME_BITS-1:0]  rx_d;
    logic [CMD_W-1:0]       cmd_q;
    logic [PAYLOAD_W-1:0]   data_q;
    logic                   valid_q;
    logic                   err_q;

    assign rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
    assign cnt_d = cnt_q + 1'b1;

    // CS rise has priority over everything, so an SCK rise seen in the same
    // cycle is discarded.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (cs_rise) begin
                state_q <= IDLE;
                if (cnt_q != '0 && cnt_q != CNT_FULL) begin
                    err_q <= 1'b1;
                end
            end else if (cs_fall) begin
                state_q <= SHIFT;
                cnt_q   <= '0;
                rx_q    <= '0;
            end else if (state_q == SHIFT && sck_rise) begin
                rx_q  <= rx_d;
                cnt_q <= cnt_d;
                if (cnt_d == CNT_FULL) begin
                    state_q <= FULL;
                    cmd_q   <= rx_d[FRAME_BITS-1 -: CMD_W];
                    data_q  <= rx_d[PAYLOAD_W-1:0];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign frame_cmd_o   = cmd_q;
    assign frame_data_o  = data_q;
    assign frame_valid_o = valid_q;
    assign frame_err_o   = err_q;

`ifdef SPI_MISO_READBACK_EN
    // Transmit register: loaded at frame start, shifted on SCK fall so the
    // next bit is settled long before the master samples on SCK rise.
    // Cleared on CS rise so MISO idles low.
    logic [FRAME_BITS-1:0] tx_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_q <= '0;
        end else if (cs_rise) begin
            tx_q <= '0;
        end else if (cs_fall) begin
            tx_q <= status_i;
        end else if (state_q == SHIFT && sck_fall) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign int_miso_o = tx_q[FRAME_BITS-1];

    logic unused_sinks;
    assign unused_sinks = rx_q[FRAME_BITS-1];
`else
    assign int_miso_o = 1'b0;

    logic unused_sinks;
    assign unused_sinks = ^{status_i, sck_fall, rx_q[FRAME_BITS-1]};
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: directed bench for spi_frame_slave. Drives SPI mode-0
// frames at 24 sys cycles per SCK half-period and checks decoded frames,
// error strobes, strobe latencies, MISO readback and reset behaviour.
module tb_spi_frame_slave;

    localparam int HALF = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        cs;
    logic        miso;
    logic [31:0] status;
    logic [7:0]  cmd;
    logic [23:0] data;
    logic        valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    spi_frame_slave dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst),
        .int_clk_i     (sck),
        .int_mosi_i    (mosi),
        .int_cs_i      (cs),
        .int_miso_o    (miso),
        .status_i      (status),
        .frame_cmd_o   (cmd),
        .frame_data_o  (data),
        .frame_valid_o (valid),
        .frame_err_o   (err)
    );

    // Clock / cycle counter
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Strobe monitor, sampled on the falling edge
    int          valid_cnt = 0;
    int          err_cnt   = 0;
    int          valid_cyc = 0;
    int          err_cyc   = 0;
    logic [7:0]  vcmd      = '0;
    logic [23:0] vdata     = '0;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
            vcmd      = cmd;
            vdata     = data;
        end
        if (err) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
    end

    // Driver tasks (inputs change on the falling sys clock edge)
    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic shift_bits(input logic [63:0] w, input int n,
                              output logic [31:0] miso_w, output int rise_cyc);
        miso_w   = '0;
        rise_cyc = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mosi = w[n-1-i];
            repeat (HALF) @(negedge clk);
            if (i < 32) miso_w = {miso_w[30:0], miso};
            sck      = 1'b1;
            rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_high(output int rise_cyc);
        repeat (HALF) @(negedge clk);
        cs       = 1'b1;
        rise_cyc = cyc;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] w, input int n,
                              output logic [31:0] miso_w, output int last_rise);
        int csr;
        cs_low();
        shift_bits(w, n, miso_w, last_rise);
        cs_high(csr);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0; status = '0;
        repeat (4) @(negedge clk);
        checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h expected 00", cmd); end
        checks++; if (data !== 24'h000000) begin errors++; $display("FAIL reset_data: got %h expected 000000", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (valid_cnt !== 0 || err_cnt !== 0) begin errors++; $display("FAIL reset_strobes: got valid=%0d err=%0d expected 0/0", valid_cnt, err_cnt); end
    endtask

    task automatic test_basic_frame();
        int v0 = valid_cnt, e0 = err_cnt, lr;
        logic [31:0] mw;
        send_frame(64'hC1000000, 32, mw, lr);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - e0); end
        checks++; if (vcmd !== 8'hC1) begin errors++; $display("FAIL basic_cmd: got %h expected C1", vcmd); end
        checks++; if (vdata !== 24'h000000) begin errors++; $display("FAIL basic_data: got %h expected 000000", vdata); end
        checks++; if (valid_cyc - lr !== 4) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 4", valid_cyc - lr); end
        checks++; if (mw !== 32'h0) begin errors++; $display("FAIL basic_miso_zero_status: got %h expected 00000000", mw); end
    endtask

    task automatic test_hold_update();
        int v0 = valid_cnt, lr;
        logic [31:0] mw;
        send_frame(64'h70674523, 32, mw, lr);
        checks++; if (vcmd !== 8'h70) begin errors++; $display("FAIL hold_cmd_strobe: got %h expected 70", vcmd); end
        checks++; if (vdata !== 24'h674523) begin errors++; $display("FAIL hold_data_strobe: got %h expected 674523", vdata); end
        repeat (200) @(negedge clk);
        checks++; if (cmd !== 8'h70) begin errors++; $display("FAIL hold_cmd: got %h expected 70", cmd); end
        checks++; if (data !== 24'h674523) begin errors++; $display("FAIL hold_data: got %h expected 674523", data); end
        send_frame(64'hC0000000, 32, mw, lr);
        checks++; if (cmd !== 8'hC0) begin errors++; $display("FAIL update_cmd: got %h expected C0", cmd); end
        checks++; if (data !== 24'h000000) begin errors++; $display("FAIL update_data: got %h expected 000000", data); end
        checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL update_valid_count: got %0d expected 2", valid_cnt - v0); end
    endtask

    task automatic test_miso();
        int lr;
        logic [31:0] mw;
        logic [31:0] exp_w;
`ifdef SPI_MISO_READBACK_EN
        exp_w = 32'hA5A50F0F;
`else
        exp_w = 32'h00000000;
`endif
        status = 32'hA5A50F0F;
        send_frame(64'h01020304, 32, mw, lr);
        checks++; if (mw !== exp_w) begin errors++; $display("FAIL miso_word: got %h expected %h", mw, exp_w); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL miso_idle: got %b expected 0", miso); end
        checks++; if (vcmd !== 8'h01 || vdata !== 24'h020304) begin errors++; $display("FAIL miso_rx: got %h/%h expected 01/020304", vcmd, vdata); end
    endtask

    task automatic test_abort();
        int v0 = valid_cnt, e0 = err_cnt, lr, csr;
        logic [31:0] mw;
        cs_low();
        shift_bits(64'hABC, 12, mw, lr);
        cs_high(csr);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_err_count: got %0d expected 1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL abort_valid_count: got %0d expected 0", valid_cnt - v0); end
        checks++; if (err_cyc - csr !== 4) begin errors++; $display("FAIL abort_err_latency: got %0d expected 4", err_cyc - csr); end
        send_frame(64'h12345678, 32, mw, lr);
        checks++; if (vcmd !== 8'h12 || vdata !== 24'h345678) begin errors++; $display("FAIL abort_next_frame: got %h/%h expected 12/345678", vcmd, vdata); end
        checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 1) begin errors++; $display("FAIL abort_next_counts: got valid=%0d err=%0d expected 1/1", valid_cnt - v0, err_cnt - e0); end
    endtask

    task automatic test_overrun();
        int v0 = valid_cnt, e0 = err_cnt, lr;
        logic [31:0] mw;
        send_frame({24'h0, 32'hDEADBEEF, 8'h5A}, 40, mw, lr);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL overrun_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL overrun_err_count: got %0d expected 0", err_cnt - e0); end
        checks++; if (cmd !== 8'hDE) begin errors++; $display("FAIL overrun_cmd: got %h expected DE", cmd); end
        checks++; if (data !== 24'hADBEEF) begin errors++; $display("FAIL overrun_data: got %h expected ADBEEF", data); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, e0, lr, csr;
        logic [31:0] mw;
        cs_low();
        shift_bits(64'h1234, 16, mw, lr);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (cmd !== 8'h00 || data !== 24'h000000) begin errors++; $display("FAIL midrst_outputs: got %h/%h expected 00/000000", cmd, data); end
        checks++; if (valid !== 1'b0 || err !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got v=%b e=%b m=%b expected 0/0/0", valid, err, miso); end
        v0 = valid_cnt; e0 = err_cnt;
        shift_bits(64'h5678, 16, mw, lr);
        cs_high(csr);
        checks++; if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_remainder: got valid=%0d err=%0d expected 0/0", valid_cnt - v0, err_cnt - e0); end
        send_frame(64'h5A3C9611, 32, mw, lr);
        checks++; if (cmd !== 8'h5A || data !== 24'h3C9611) begin errors++; $display("FAIL midrst_next_frame: got %h/%h expected 5A/3C9611", cmd, data); end
        checks++; if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_next_counts: got valid=%0d err=%0d expected 1/0", valid_cnt - v0, err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_update();
        test_miso();
        test_abort();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

SPI slave front end of the function generator. Brings the external interface pins (`int_clk_i`, `int_mosi_i`, `int_cs_i`, `int_miso_o`) into the `sys_clk_i` domain. Each chip-select window carries one 32-bit command frame, which the block assembles and presents as a one-cycle command strobe (8-bit command, 24-bit payload) to the downstream register/DDS control logic. It also shifts a 32-bit status word back on MISO during the same window.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per SPI input, minimum 2.
- `FRAME_BITS`, default 32: bits per frame, taken from the package constant.
- `sys_clk_i` in 1: system clock, 48 MHz nominal. This is the only clock.
- `sys_rst_i` in 1: reset, synchronous, active-high.
- `int_clk_i` in 1: SPI SCK, mode 0, asynchronous to `sys_clk_i`.
- `int_mosi_i` in 1: SPI data in, MSB first.
- `int_cs_i` in 1: SPI chip select, active-low.
- `int_miso_o` out 1: SPI data out, MSB first.
- `status_i` in 32: readback word, latched at frame start.
- `frame_cmd_o` out 8: byte 0 of the last complete frame.
- `frame_data_o` out 24: bytes 1..3 of the last complete frame, byte 1 in bits [23:16].
- `frame_valid_o` out 1: one-cycle strobe when a complete frame is received.
- `frame_err_o` out 1: one-cycle strobe when a frame is aborted (1..31 bits received).

## Operation
- All three SPI inputs pass through `SYNC_STAGES` flops and then one edge-detect register. SCK rise, SCK fall, CS fall and CS rise are each produced as a single-cycle pulse. MOSI is delayed by the same number of stages as SCK, so the sampled MOSI value is the one present at the SCK edge.
- States:
  - IDLE: CS high.
  - SHIFT: CS low, bit count < 32.
  - FULL: 32 bits received.
- IDLE -> SHIFT on CS fall:
  - clear the 6-bit bit counter and the receive shift register;
  - load `status_i` into the transmit shift register.
- SHIFT, on SCK rise:
  - shift the synchronized MOSI into the LSB of the receive register;
  - increment the counter.
  - On the 32nd bit, go to FULL and register cmd/data from the receive register.
- SHIFT, on SCK fall: shift the transmit register left by one and fill the LSB with 0.
- FULL: all further SCK edges are ignored, with no overrun error. The receive register and counter hold.
- Any state -> IDLE on CS rise. If the counter is 1..31 at that point, pulse `frame_err_o`. A count of 0 or 32 produces no error.
- CS fall and CS rise detected in the same cycle cannot occur because of the edge-detect register. If SCK rise and CS rise are detected in the same cycle, CS rise wins and the bit is discarded.
- `frame_cmd_o` and `frame_data_o` hold their values until the next complete frame.
- Reset, including in the middle of a frame, returns the block to IDLE and forces:
  - `frame_cmd_o` = 0x00, `frame_data_o` = 0x000000;
  - `frame_valid_o` = 0, `frame_err_o` = 0;
  - `int_miso_o` = 0;
  - counter and both shift registers = 0.
- After reset, a frame already in progress (CS low) is ignored until the next CS fall.

## Timing
- Sampling rate: `sys_clk_i` must be at least 8× SCK. The nominal case is 48 MHz against 1 MHz, which gives 24 sys cycles per SCK half-period.
- Edge detection latency: SYNC_STAGES+1 cycles from a pin edge to its internal pulse, i.e. 3 cycles at default.
- Frame strobe latency: `frame_valid_o` is asserted on the cycle after the 32nd SCK-rise pulse, with cmd/data valid in that same cycle. That is 4 sys cycles after the pin edge at default.
- Error strobe latency: `frame_err_o` is asserted the cycle after the CS-rise pulse.
- MISO timing:
  - `int_miso_o` is driven from a register as the transmit MSB while in SHIFT/FULL, and is 0 in IDLE.
  - Bit 31 appears 4 cycles after the CS fall pin edge.
  - Each following bit appears 4 cycles after the corresponding SCK fall, well within the 24-cycle setup window before the next SCK rise.

## Configuration
- `SPI_MISO_READBACK_EN`:
  - Defined: the transmit shift register and the `status_i` latch are built, and MISO behaves as described above.
  - Undefined: the transmit path is removed, `int_miso_o` is tied to 0, and `status_i` is ignored. Receive behaviour is identical in both builds.

## Structure
- Shared package `fungen_pkg`, holding:
  - `FRAME_BITS`=32, `CMD_W`=8, `PAYLOAD_W`=24;
  - the state enum `spi_state_t` {IDLE, SHIFT, FULL}.
- Sub-module `sync_edge`: parameterized synchronizer plus rise/fall pulse generator, instantiated for SCK and CS. MOSI uses the sync chain only.

## Test plan
- Frame C1 00 00 00 at SCK 1 MHz -> exactly one `frame_valid_o` pulse with cmd=0xC1 and data=0x000000, and `frame_err_o` stays 0.
- Frame 70 67 45 23 -> cmd=0x70 and data=0x674523. Outputs hold until the next frame, and a following C0 00 00 00 updates them to 0xC0/0x000000.
- `status_i`=0xA5A50F0F with `SPI_MISO_READBACK_EN` defined -> MISO sampled on SCK rise reads 0xA5A50F0F. Without the macro, MISO is constantly 0.
- CS raised after 12 bits -> one `frame_err_o` pulse and no `frame_valid_o`. The next full frame, 0x12345678, decodes correctly as cmd=0x12 and data=0x345678.
- 40 SCK cycles in one CS window with first 32 bits 0xDEADBEEF -> one valid pulse with cmd=0xDE and data=0xADBEEF, extra bits ignored, no error.
- `sys_rst_i` asserted for 2 cycles after 16 bits -> all outputs 0 on the next cycle. The remainder of that frame gives no valid and no error, and the next frame decodes normally.
